// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file (NUM_RD comb reads, two write ports) with a
// per-register busy scoreboard. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.

module regfile_mp_rdport #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
  input  logic [DEPTH-1:0]              busy_i,
`ifdef RF_BYPASS_EN
  input  logic                          wa_v_i,
  input  logic [ADDR_W-1:0]             wa_addr_i,
  input  logic [DATA_W-1:0]             wa_data_i,
  input  logic                          wb_v_i,
  input  logic [ADDR_W-1:0]             wb_addr_i,
  input  logic [DATA_W-1:0]             wb_data_i,
  input  logic                          mark_v_i,
  input  logic [ADDR_W-1:0]             mark_addr_i,
`endif
  output logic [DATA_W-1:0]             data_o,
  output logic                          busy_o
);

  always_comb begin
    data_o = mem_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef RF_BYPASS_EN
    // A forwarded write retires the old producer; only a same-cycle mark re-arms busy.
    if (wb_v_i && (wb_addr_i == addr_i)) begin
      data_o = wb_data_i;
      busy_o = mark_v_i && (mark_addr_i == addr_i);
    end else if (wa_v_i && (wa_addr_i == addr_i)) begin
      data_o = wa_data_i;
      busy_o = mark_v_i && (mark_addr_i == addr_i);
    end
`endif
    if (addr_i == '0) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

endmodule

module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic                         wa_v, wb_v, mark_v;

  // Register 0 is hardwired; requests during reset are dropped (and never forwarded).
  assign wa_v   = wa_en   && (wa_addr   != '0) && !rst;
  assign wb_v   = wb_en   && (wb_addr   != '0) && !rst;
  assign mark_v = mark_en && (mark_addr != '0) && !rst;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    // B after A so B wins a same-address collision; mark last so it beats a write clear.
    if (wa_v) begin
      mem_d[wa_addr]  = wa_data;
      busy_d[wa_addr] = 1'b0;
    end
    if (wb_v) begin
      mem_d[wb_addr]  = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (mark_v) busy_d[mark_addr] = 1'b1;
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .addr_i      (rd_addr[i*ADDR_W +: ADDR_W]),
      .mem_i       (mem_q),
      .busy_i      (busy_q),
`ifdef RF_BYPASS_EN
      .wa_v_i      (wa_v),
      .wa_addr_i   (wa_addr),
      .wa_data_i   (wa_data),
      .wb_v_i      (wb_v),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .mark_v_i    (mark_v),
      .mark_addr_i (mark_addr),
`endif
      .data_o      (rd_data[i*DATA_W +: DATA_W]),
      .busy_o      (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus queues expected reads, a negedge monitor
// pops and compares them against a default instance and a 4-port 16-bit instance.

module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance A: defaults (32-bit, 5-bit address, 2 read ports)
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en, wb_en, mark_en, any_busy;
  logic [4:0]  wa_addr, wb_addr, mark_addr;
  logic [31:0] wa_data, wb_data;

  // Instance B: 16-bit, 3-bit address, 4 read ports
  logic [11:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wa_en, b_wb_en, b_mark_en, b_any_busy;
  logic [2:0]  b_wa_addr, b_wb_addr, b_mark_addr;
  logic [15:0] b_wa_data, b_wb_data;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .any_busy(any_busy)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_dut4 (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wa_en(b_wa_en), .wa_addr(b_wa_addr), .wa_data(b_wa_data),
    .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .mark_en(b_mark_en), .mark_addr(b_mark_addr), .any_busy(b_any_busy)
  );

  // port < 0 means "check any_busy only"
  typedef struct {
    int          dut;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] ad;
      logic        ab;
      e = q.pop_front();
      if (e.port < 0) begin
        ad = '0;
        ab = (e.dut == 0) ? any_busy : b_any_busy;
      end else if (e.dut == 0) begin
        ad = rd_data[e.port*32 +: 32];
        ab = rd_busy[e.port];
      end else begin
        ad = {16'h0, b_rd_data[e.port*16 +: 16]};
        ab = b_rd_busy[e.port];
      end
      checks++;
      if (ad === e.data && ab === e.busy) passed++;
      else $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                    e.nm, ad, ab, e.data, e.busy);
    end
  end

  task automatic exp_rd(input int dut, input int port, input logic [31:0] d,
                        input logic b, input string nm);
    exp_t e;
    e.dut = dut; e.port = port; e.data = d; e.busy = b; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic exp_any(input int dut, input logic b, input string nm);
    exp_rd(dut, -1, 32'h0, b, nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wa_en = 1'b0; wb_en = 1'b0; mark_en = 1'b0;
    b_wa_en = 1'b0; b_wb_en = 1'b0; b_mark_en = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    wa_en = 1'b1; wa_addr = a; wa_data = d;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic mark(input logic [4:0] a);
    mark_en = 1'b1; mark_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0; wa_en = 0; wb_en = 0; mark_en = 0;
    wa_addr = '0; wb_addr = '0; mark_addr = '0; wa_data = '0; wb_data = '0;
    b_rd_addr = '0; b_wa_en = 0; b_wb_en = 0; b_mark_en = 0;
    b_wa_addr = '0; b_wb_addr = '0; b_mark_addr = '0; b_wa_data = '0; b_wb_data = '0;

    // Reset state
    tick();
    set_rd(5, 0);
    exp_rd(0, 0, 32'h0, 1'b0, "reset_r5");
    exp_rd(0, 1, 32'h0, 1'b0, "reset_r0");
    exp_any(0, 1'b0, "reset_any");
    exp_any(1, 1'b0, "reset_any4");

    // Preload r5, mark r6
    tick();
    rst = 1'b0;
    set_rd(1, 2);
    wr_a(5, 32'h1234); mark(6);
    exp_rd(0, 0, 32'h0, 1'b0, "idle_r1");

    tick();
    set_rd(5, 6);
    exp_rd(0, 0, 32'h1234, 1'b0, "preload_r5");
    exp_rd(0, 1, 32'h0, 1'b1, "preload_r6_busy");
    exp_any(0, 1'b1, "preload_any");

    // Asynchronous reset between edges; write presented during reset must drop
    tick();
    wr_a(5, 32'hDEAD);
    exp_rd(0, 0, 32'h0, 1'b0, "async_rst_r5");
    exp_rd(0, 1, 32'h0, 1'b0, "async_rst_r6");
    exp_any(0, 1'b0, "async_rst_any");
    #1 rst = 1'b1;

    tick();
    rst = 1'b0;
    exp_rd(0, 0, 32'h0, 1'b0, "rst_write_dropped");

    // Dual write, different addresses
    tick();
    set_rd(1, 2);
    wr_a(3, 32'hA); wr_b(4, 32'hB);
    exp_rd(0, 0, 32'h0, 1'b0, "dual_idle_r1");

    tick();
    set_rd(3, 4);
    wr_a(7, 32'h1); wr_b(7, 32'h2);
    exp_rd(0, 0, 32'hA, 1'b0, "dual_r3");
    exp_rd(0, 1, 32'hB, 1'b0, "dual_r4");

    tick();
    set_rd(7, 0);
    exp_rd(0, 0, 32'h2, 1'b0, "collide_b_wins");

    // Register zero ignores writes and marks
    tick();
    set_rd(0, 7);
    wr_a(0, 32'hFFFFFFFF); mark(0);
    exp_rd(0, 0, 32'h0, 1'b0, "r0_same_cycle");

    tick();
    set_rd(0, 3);
    exp_rd(0, 0, 32'h0, 1'b0, "r0_after");
    exp_any(0, 1'b0, "r0_any");

    // Scoreboard: mark, clear by write, mark beats write
    tick();
    set_rd(9, 0);
    mark(9);
    exp_rd(0, 0, 32'h0, 1'b0, "mark_r9_same_cycle");

    tick();
    exp_rd(0, 0, 32'h0, 1'b1, "mark_r9_busy");
    exp_any(0, 1'b1, "mark_r9_any");

    tick();
    wr_b(9, 32'h55);
`ifdef RF_BYPASS_EN
    exp_rd(0, 0, 32'h55, 1'b0, "wb_r9_bypass");
`else
    exp_rd(0, 0, 32'h0, 1'b1, "wb_r9_pending");
`endif

    tick();
    exp_rd(0, 0, 32'h55, 1'b0, "wb_r9_cleared");
    exp_any(0, 1'b0, "wb_r9_any");

    tick();
    wr_a(9, 32'h66); mark(9);
`ifdef RF_BYPASS_EN
    exp_rd(0, 0, 32'h66, 1'b1, "mark_wr_r9_bypass");
`else
    exp_rd(0, 0, 32'h55, 1'b0, "mark_wr_r9_old");
`endif

    tick();
    exp_rd(0, 0, 32'h66, 1'b1, "mark_beats_clear");
    exp_any(0, 1'b1, "mark_beats_any");

    // Same-cycle read of a register being written
    tick();
    set_rd(12, 9);
    wr_a(12, 32'h0BAD);

    tick();
    wr_a(12, 32'hC0DE);
`ifdef RF_BYPASS_EN
    exp_rd(0, 0, 32'hC0DE, 1'b0, "bypass_r12");
`else
    exp_rd(0, 0, 32'h0BAD, 1'b0, "nobypass_r12_old");
`endif
    exp_rd(0, 1, 32'h66, 1'b1, "bypass_other_port");

    tick();
    exp_rd(0, 0, 32'hC0DE, 1'b0, "r12_after_edge");

    // Four-port instance
    tick();
    b_wa_en = 1'b1; b_wa_addr = 3'd1; b_wa_data = 16'h11;
    b_wb_en = 1'b1; b_wb_addr = 3'd2; b_wb_data = 16'h22;

    tick();
    b_wa_en = 1'b1; b_wa_addr = 3'd3; b_wa_data = 16'h33;
    b_wb_en = 1'b1; b_wb_addr = 3'd4; b_wb_data = 16'h44;

    tick();
    b_rd_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    exp_rd(1, 0, 32'h11, 1'b0, "p4_port0_r1");
    exp_rd(1, 1, 32'h22, 1'b0, "p4_port1_r2");
    exp_rd(1, 2, 32'h33, 1'b0, "p4_port2_r3");
    exp_rd(1, 3, 32'h44, 1'b0, "p4_port3_r4");

    tick();
    b_rd_addr = {3'd1, 3'd2, 3'd0, 3'd4};
    exp_rd(1, 0, 32'h44, 1'b0, "p4_port0_r4");
    exp_rd(1, 1, 32'h0,  1'b0, "p4_port1_r0");
    exp_rd(1, 2, 32'h22, 1'b0, "p4_port2_r2");
    exp_rd(1, 3, 32'h11, 1'b0, "p4_port3_r1");

    tick();
    #10;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
